timer_sched: RTL

- Shares one programmable timeout counter among NCH requesters.
- Each requester asks for a timeout of its own length. A round-robin arbiter grants the counter to one channel at a time. The block runs that channel's count, then pulses that channel's done output.
- Sits between the per-channel control logic and the shared counting datapath; it replaces the separate fixed-terminal timers each channel would otherwise need.

---
 rtl/timer_sched.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/timer_sched.sv
// timer_sched: one programmable timeout counter shared round-robin among NCH
// requesting channels. In IDLE the first requesting channel at or above the
// round-robin pointer wins the counter. It receives a one-cycle gnt pulse.
// The counter then runs lim+1 cycles and ends with a one-cycle done pulse to
// that channel, unless cancel aborts the run first.
//
// Ports:
//   clk_in    rising-edge clock
//   arst      asynchronous active-high reset
//   req       per-channel request level (bit i = channel i)
//   load_val  per-channel limit, channel i at [i*CW +: CW], sampled at grant
//   cancel    synchronous abort of the running timeout (ignored in IDLE)
//   gnt       one-hot one-cycle grant pulse
//   done      one-hot one-cycle terminal pulse to the owning channel
//   busy      high while the counter is owned
//   owner     index of the current or most recent owner
module timer_sched #(
    parameter int NCH = 4,
    parameter int CW  = 8,
    parameter int IW  = 2
) (
    input  logic              clk_in,
    input  logic              arst,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*CW-1:0] load_val,
    input  logic              cancel,
    output logic [NCH-1:0]    gnt,
    output logic [NCH-1:0]    done,
    output logic              busy,
    output logic [IW-1:0]     owner
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [CW-1:0]  lim_reg, lim_next;
    logic [IW-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [IW-1:0]  owner_reg, owner_next;
    logic [NCH-1:0] gnt_reg, gnt_next;
    logic [NCH-1:0] done_reg, done_next;
    logic           busy_reg, busy_next;

    // Per-channel limit slices, indexed by channel number.
    logic [CW-1:0]  lim_arr [NCH];

    // Requests viewed in search order: entry k is channel (rr_ptr + k) mod NCH.
    logic [IW-1:0]  cand_idx [NCH];
    logic [NCH-1:0] cand_req;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic [IW:0] sum;

            assign lim_arr[gi] = load_val[gi*CW +: CW];

            // One extra bit holds rr_ptr + gi without overflow; a single
            // conditional subtract is enough because the sum stays below 2*NCH.
            assign sum = {1'b0, rr_ptr_reg} + (IW+1)'(gi);
            assign cand_idx[gi] = (sum >= (IW+1)'(NCH)) ? (sum[IW-1:0] - IW'(NCH))
                                                        : sum[IW-1:0];
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Winner: the first requesting channel in search order.
    logic          found;
    logic [IW-1:0] win;

    always_comb begin
        found = 1'b0;
        win   = cand_idx[0];
        for (int k = 0; k < NCH; k++) begin
            if (!found && cand_req[k]) begin
                found = 1'b1;
                win   = cand_idx[k];
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        lim_next    = lim_reg;
        rr_ptr_next = rr_ptr_reg;
        owner_next  = owner_reg;
        gnt_next    = '0;
        done_next   = '0;
        busy_next   = busy_reg;

        case (state_reg)
            IDLE: begin
                // cancel has no meaning here and must not suppress a grant.
                if (found) begin
                    gnt_next    = NCH'(1) << win;
                    owner_next  = win;
                    lim_next    = lim_arr[win];
                    cnt_next    = '0;
                    busy_next   = 1'b1;
                    rr_ptr_next = (win == IW'(NCH-1)) ? '0 : win + 1'b1;
                    state_next  = RUN;
                end
            end
            RUN: begin
                // cancel takes priority even on the terminal edge: no done.
                if (cancel) begin
                    cnt_next   = '0;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else if (cnt_reg == lim_reg) begin
                    done_next  = NCH'(1) << owner_reg;
                    cnt_next   = '0;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                cnt_next   = '0;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge arst) begin
        if (arst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            lim_reg    <= '0;
            rr_ptr_reg <= '0;
            owner_reg  <= '0;
            gnt_reg    <= '0;
            done_reg   <= '0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            lim_reg    <= lim_next;
            rr_ptr_reg <= rr_ptr_next;
            owner_reg  <= owner_next;
            gnt_reg    <= gnt_next;
            done_reg   <= done_next;
            busy_reg   <= busy_next;
        end
    end

    assign gnt   = gnt_reg;
    assign done  = done_reg;
    assign busy  = busy_reg;
    assign owner = owner_reg;

endmodule
